// File: rtl/swap_scheduler.sv
// swap_scheduler: round-robin arbiter plus 3-step exchange sequencer that lets
// N_REQ requesters share one swap datapath on a register file.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   req               per-requester level request, held until ack
//   addr_a, addr_b    packed word addresses, requester i at [i*ADDR_W +: ADDR_W]
//   ack               one-cycle completion pulse to the served requester
//   busy              high in every state except IDLE
//   grant_id          index of the requester being served
//   step              0=IDLE/DONE, 1=LOAD, 2=COPY, 3=WRITE
//   rd_addr, rd_data  combinational read port of the register file
//   wr_en, wr_addr,   write port of the register file
//   wr_data
//   swap_cnt          completed swaps, wraps at 16 bits
module swap_scheduler #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   addr_a,
  input  logic [N_REQ*ADDR_W-1:0]   addr_b,
  output logic [N_REQ-1:0]          ack,
  output logic                      busy,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic [1:0]                step,
  output logic [ADDR_W-1:0]         rd_addr,
  input  logic [DATA_W-1:0]         rd_data,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic [15:0]               swap_cnt
);

  localparam int unsigned ID_W  = $clog2(N_REQ);
  localparam int unsigned CNT_W = 16;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_COPY  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]        state, state_d;
  logic [ID_W-1:0]   rr_ptr, rr_ptr_d;
  logic [ID_W-1:0]   grant_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [ADDR_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] temp_q, temp_d;
  logic [CNT_W-1:0]  cnt_d;

  logic              pick_valid;
  logic [ID_W-1:0]   pick_id;
  logic [ADDR_W-1:0] pick_a, pick_b;

  // (base + off) mod N_REQ, used for the cyclic search and pointer advance
  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                               input int unsigned     off);
    int unsigned s;
    s = (32'(base) + off) % N_REQ;
    return ID_W'(s);
  endfunction

  // Round-robin pick: first set req bit at or after rr_ptr, cyclically
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!pick_valid && req[wrap_idx(rr_ptr, k)]) begin
        pick_valid = 1'b1;
        pick_id    = wrap_idx(rr_ptr, k);
      end
    end
    pick_a = addr_a[32'(pick_id) * ADDR_W +: ADDR_W];
    pick_b = addr_b[32'(pick_id) * ADDR_W +: ADDR_W];
  end

  // Next-state and output decode
  always_comb begin
    state_d  = state;
    rr_ptr_d = rr_ptr;
    grant_d  = grant_id;
    a_d      = a_q;
    b_d      = b_q;
    temp_d   = temp_q;
    cnt_d    = swap_cnt;

    ack      = '0;
    busy     = (state != S_IDLE);
    step     = 2'd0;
    rd_addr  = a_q;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;

    case (state)
      S_IDLE: begin
        if (pick_valid) begin
          grant_d  = pick_id;
          a_d      = pick_a;
          b_d      = pick_b;
          rr_ptr_d = wrap_idx(pick_id, 1);
          // A==B needs no memory traffic; go straight to completion
          state_d  = (pick_a != pick_b) ? S_LOAD : S_DONE;
        end
      end
      S_LOAD: begin
        step    = 2'd1;
        rd_addr = a_q;
        temp_d  = rd_data;
        state_d = S_COPY;
      end
      S_COPY: begin
        step    = 2'd2;
        rd_addr = b_q;
        wr_en   = 1'b1;
        wr_addr = a_q;
        wr_data = rd_data;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        step    = 2'd3;
        wr_en   = 1'b1;
        wr_addr = b_q;
        wr_data = temp_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        ack[grant_id] = 1'b1;
        cnt_d         = swap_cnt + CNT_W'(1);
        state_d       = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and latch registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      a_q      <= '0;
      b_q      <= '0;
      temp_q   <= '0;
      swap_cnt <= '0;
    end else begin
      state    <= state_d;
      rr_ptr   <= rr_ptr_d;
      grant_id <= grant_d;
      a_q      <= a_d;
      b_q      <= b_d;
      temp_q   <= temp_d;
      swap_cnt <= cnt_d;
    end
  end

endmodule
